alu_share_ctrl: RTL

//  Shares one yAlu instance (32-bit AND/OR/ADD/SUB, op 3 bits) among NREQ requesters.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_share_ctrl_rr_pick.sv | 31 +++
 rtl/yalu.sv | 29 ++
 rtl/alu_share_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode legality helper and controller FSM state type.
package alu_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_AND = 3'b000;
    localparam logic [OPW-1:0] OP_OR  = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    // True for the four opcodes the ALU officially supports.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin select starting at ptr.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int unsigned cand;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!any && valid[IDW'(cand)]) begin
                any = 1'b1;
                idx = IDW'(cand);
                gnt = NREQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/yalu.sv
// yAlu: AND/OR/ADD/SUB ALU; op[2] inverts b for subtract, op[1:0] picks the result.
// op[1:0]=11 yields signed set-less-than; ex flags a zero result.
module yAlu #(
    parameter int unsigned W = 32
) (
    output logic [W-1:0] z,
    output logic         ex,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op
);

    logic [W-1:0] b_eff;
    logic [W-1:0] sum;

    // Result mux over logic, arithmetic and compare paths.
    always_comb begin
        b_eff = op[2] ? ~b : b;
        sum   = a + b_eff + W'(op[2]);
        case (op[1:0])
            2'b00:   z = a & b;
            2'b01:   z = a | b;
            2'b10:   z = sum;
            default: z = W'($signed(a) < $signed(b));
        endcase
        ex = (z == '0);
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one yAlu among NREQ requesters, round-robin, one op in flight.
// Optional macro ALU_OP_CHECK_EN: illegal opcodes return resp_err=1 with zero data.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic              resp_ex,
    output logic              resp_err
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cap_id;
    logic [W-1:0]     cap_a;
    logic [W-1:0]     cap_b;
    logic [OPW-1:0]   cap_op;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [OPW-1:0]   sel_op;
    logic [W-1:0]     alu_z;
    logic             alu_ex;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Operand/opcode mux for the current round-robin winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    // Accept only while idle and out of reset.
    assign req_ready = (rst_n && (state == S_IDLE)) ? pick_gnt : '0;

    yAlu #(.W(W)) u_alu (
        .z  (alu_z),
        .ex (alu_ex),
        .a  (cap_a),
        .b  (cap_b),
        .op (cap_op)
    );

`ifndef ALU_OP_CHECK_EN
    assign resp_err = 1'b0;
`endif

    // Controller FSM: capture, execute, hold response until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cap_id     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_ex    <= 1'b0;
`ifdef ALU_OP_CHECK_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        cap_op <= sel_op;
                        cap_id <= pick_idx;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_id    <= cap_id;
                    resp_valid <= 1'b1;
`ifdef ALU_OP_CHECK_EN
                    if (op_legal(cap_op)) begin
                        resp_data <= alu_z;
                        resp_ex   <= alu_ex;
                        resp_err  <= 1'b0;
                    end else begin
                        resp_data <= '0;
                        resp_ex   <= 1'b0;
                        resp_err  <= 1'b1;
                    end
`else
                    resp_data  <= alu_z;
                    resp_ex    <= alu_ex;
`endif
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= IDW'((32'(cap_id) + 32'd1) % NREQ);
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
